mem_bus_arbiter: RTL

- Shares the single-port main memory between the CPU control unit (status_counter/isr_decoder path) and one DMA/IO requester.
- Sequences each memory transaction: arbitration, strobe generation (MREQ_N, R_W_N), wait states and completion detection.
- Returns a one-cycle ACK to the winning requester; this is the ACK that status_counter consumes.
- Sits between the control unit and the memory model in top.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/rr_arb2.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the control unit, the memory arbiter and the ISR decoder.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_DMA = 1'b1;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// requester that did not win last time.
module rr_arb2
   import cpu_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       valid,
   output logic       grant
);

   always_comb begin
      valid = |req;
      grant = GNT_CPU;
      if (req == 2'b11) begin
         grant = ~last_grant;
      end else if (req[1]) begin
         grant = GNT_DMA;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares single-port main memory between the CPU and one DMA requester and
// sequences each transaction (strobe, wait states, timeout, one-cycle ack).
module mem_bus_arbiter
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int WAIT_CYC = 1,
   parameter int TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mem_req_n,
   output logic              mem_r_w_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_rdy
);

   localparam logic [7:0] WAIT_V = 8'(WAIT_CYC);
   localparam logic [7:0] TMO_V  = 8'(TIMEOUT);

   state_t     state;
   state_t     state_next;
   logic [7:0] cnt;
   logic       winner;
   logic       last_grant;
   logic       arb_valid;
   logic       arb_grant;
   logic       complete;
   logic       timeout;

   rr_arb2 u_arb (
      .req        ({dma_req, cpu_req}),
      .last_grant (last_grant),
      .valid      (arb_valid),
      .grant      (arb_grant)
   );

   // A ready that arrives on the timeout cycle still counts as completion.
   always_comb begin
      complete   = (state == ACCESS) && (cnt >= WAIT_V) && mem_rdy;
      timeout    = (state == ACCESS) && !complete && (cnt == TMO_V);
      state_next = state;
      case (state)
         IDLE:    if (arb_valid) state_next = ACCESS;
         ACCESS:  if (complete || timeout) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= '0;
         winner     <= GNT_CPU;
         last_grant <= GNT_DMA;
         cpu_ack    <= 1'b0;
         dma_ack    <= 1'b0;
         err        <= 1'b0;
         rdata      <= '0;
         mem_req_n  <= 1'b1;
         mem_r_w_n  <= READ;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state   <= state_next;
         cpu_ack <= 1'b0;
         dma_ack <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  winner    <= arb_grant;
                  cnt       <= '0;
                  mem_req_n <= 1'b0;
                  if (arb_grant == GNT_DMA) begin
                     mem_r_w_n <= dma_we ? WRITE : READ;
                     mem_addr  <= dma_addr;
                     mem_wdata <= dma_wdata;
                  end else begin
                     mem_r_w_n <= cpu_we ? WRITE : READ;
                     mem_addr  <= cpu_addr;
                     mem_wdata <= cpu_wdata;
                  end
               end
            end
            ACCESS: begin
               if (complete || timeout) begin
                  mem_req_n  <= 1'b1;
                  mem_r_w_n  <= READ;
                  cpu_ack    <= (winner == GNT_CPU);
                  dma_ack    <= (winner == GNT_DMA);
                  err        <= timeout;
                  last_grant <= winner;
                  if (timeout) begin
                     rdata <= '0;
                  end else if (mem_r_w_n == READ) begin
                     rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
